// File: rtl/ysyx_25010008_axi_pkg.sv
// Shared AXI4-Lite definitions: response codes and the SRAM responder state encoding.
package ysyx_25010008_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_R_WAIT    = 3'd1;
    localparam logic [2:0] ST_R_RESP    = 3'd2;
    localparam logic [2:0] ST_W_COLLECT = 3'd3;
    localparam logic [2:0] ST_W_WAIT    = 3'd4;
    localparam logic [2:0] ST_B_RESP    = 3'd5;

endpackage

// File: rtl/ysyx_25010008_sram_array.sv
// Word-wide SRAM with one asynchronous read port and one byte-masked write port.
module ysyx_25010008_sram_array #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    assign rdata = mem[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_25010008_axi_sram.sv
// AXI4-Lite SRAM responder: one transaction at a time, fixed response latency, SLVERR outside the window.
module ysyx_25010008_axi_sram
    import ysyx_25010008_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    // With zero latency the WAIT states are skipped so the response lands one cycle after the handshake.
    localparam bit         LAT_ZERO = (LATENCY == 0);
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    logic [2:0]  state, next_state;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_cap, w_cap;
    logic        ar_hs, aw_hs, w_hs, write_last;
    logic        read_done, write_done, mem_we, in_range;
    logic [31:0] mem_addr, offset, mem_rdata, commit_wdata;
    logic [3:0]  commit_wstrb;

    assign arready = !reset && (state == ST_IDLE);
    assign awready = !reset && ((state == ST_IDLE && !arvalid) || (state == ST_W_COLLECT && !aw_cap));
    assign wready  = !reset && ((state == ST_IDLE && !arvalid) || (state == ST_W_COLLECT && !w_cap));

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign write_last = (aw_cap || aw_hs) && (w_cap || w_hs) &&
                        (state == ST_IDLE || state == ST_W_COLLECT);

    // Handshake-cycle values bypass the capture registers so zero latency can use them directly.
    assign mem_addr     = ar_hs ? araddr : (aw_hs ? awaddr : addr_q);
    assign commit_wdata = w_hs ? wdata : wdata_q;
    assign commit_wstrb = w_hs ? wstrb : wstrb_q;
    assign offset       = mem_addr - BASE_ADDR;
    assign in_range     = (mem_addr >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (ar_hs)
                    next_state = LAT_ZERO ? ST_R_RESP : ST_R_WAIT;
                else if (write_last)
                    next_state = LAT_ZERO ? ST_B_RESP : ST_W_WAIT;
                else if (aw_hs || w_hs)
                    next_state = ST_W_COLLECT;
            end
            ST_W_COLLECT: if (write_last) next_state = LAT_ZERO ? ST_B_RESP : ST_W_WAIT;
            ST_R_WAIT:    if (cnt == 4'd0) next_state = ST_R_RESP;
            ST_W_WAIT:    if (cnt == 4'd0) next_state = ST_B_RESP;
            ST_R_RESP:    if (rready) next_state = ST_IDLE;
            ST_B_RESP:    if (bready) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    assign read_done  = (next_state == ST_R_RESP) && (state != ST_R_RESP);
    assign write_done = (next_state == ST_B_RESP) && (state != ST_B_RESP);
    assign mem_we     = write_done && in_range && !reset;

    ysyx_25010008_sram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clock (clock),
        .we    (mem_we),
        .addr  (offset[DEPTH_LOG2+1:2]),
        .wdata (commit_wdata),
        .wstrb (commit_wstrb),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            aw_cap  <= 1'b0;
            w_cap   <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= 32'd0;
            rresp   <= RESP_OKAY;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            state <= next_state;
            if (state != ST_R_WAIT && state != ST_W_WAIT)
                cnt <= CNT_INIT;
            else
                cnt <= cnt - 4'd1;
            if (ar_hs)
                addr_q <= araddr;
            else if (aw_hs)
                addr_q <= awaddr;
            if (aw_hs)
                aw_cap <= 1'b1;
            if (w_hs) begin
                w_cap   <= 1'b1;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (write_done) begin
                aw_cap <= 1'b0;
                w_cap  <= 1'b0;
                bvalid <= 1'b1;
                bresp  <= in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (read_done) begin
                rvalid <= 1'b1;
                rdata  <= in_range ? mem_rdata : 32'd0;
                rresp  <= in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (state == ST_R_RESP && rready)
                rvalid <= 1'b0;
            if (state == ST_B_RESP && bready)
                bvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_axi_sram.sv
// Scoreboard bench for the AXI4-Lite SRAM responder (LATENCY 1 main instance, LATENCY 0 side instance).
module tb_ysyx_25010008_axi_sram;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic [1:0]  rresp, bresp;

    logic [31:0] z_araddr = '0, z_awaddr = '0, z_wdata = '0, z_rdata;
    logic        z_arvalid = 1'b0, z_arready, z_rvalid, z_rready = 1'b0;
    logic        z_awvalid = 1'b0, z_awready, z_wvalid = 1'b0, z_wready, z_bvalid, z_bready = 1'b0;
    logic [3:0]  z_wstrb = '0;
    logic [1:0]  z_rresp, z_bresp;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] model_mem [int];
    logic [31:0] rd_data_q [$];
    logic [1:0]  rd_resp_q [$];
    logic [1:0]  wr_resp_q [$];

    always #5 clock = ~clock;

    ysyx_25010008_axi_sram #(.BASE_ADDR(BASE), .DEPTH_LOG2(12), .LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    ysyx_25010008_axi_sram #(.BASE_ADDR(BASE), .DEPTH_LOG2(12), .LATENCY(0)) dut_lat0 (
        .clock(clock), .reset(reset),
        .araddr(z_araddr), .arvalid(z_arvalid), .arready(z_arready),
        .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(z_rready),
        .awaddr(z_awaddr), .awvalid(z_awvalid), .awready(z_awready),
        .wdata(z_wdata), .wstrb(z_wstrb), .wvalid(z_wvalid), .wready(z_wready),
        .bresp(z_bresp), .bvalid(z_bvalid), .bready(z_bready)
    );

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h0000_4000);
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Expected results are queued here when a transaction is issued.
    task automatic expect_read(input logic [31:0] a);
        if (addr_ok(a)) begin
            rd_data_q.push_back(model_mem[word_idx(a)]);
            rd_resp_q.push_back(2'b00);
        end else begin
            rd_data_q.push_back(32'd0);
            rd_resp_q.push_back(2'b10);
        end
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (addr_ok(a)) begin
            w = model_mem.exists(word_idx(a)) ? model_mem[word_idx(a)] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model_mem[word_idx(a)] = w;
            wr_resp_q.push_back(2'b00);
        end else begin
            wr_resp_q.push_back(2'b10);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, output int lat,
                           output logic [31:0] d, output logic [1:0] r, output bit stable, output bit ok);
        int waitc;
        ok = 1'b1; stable = 1'b1; lat = 0; d = '0; r = '0; waitc = 0;
        @(negedge clock);
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && waitc < 20) begin @(negedge clock); #1; waitc++; end
        if (!arready) begin arvalid = 1'b0; ok = 1'b0; return; end
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0; lat = 1;
        while (rvalid !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
        if (rvalid !== 1'b1) begin ok = 1'b0; return; end
        d = rdata; r = rresp;
        repeat (hold) begin
            @(negedge clock);
            if (rvalid !== 1'b1 || rdata !== d || rresp !== r) stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead,
                            output int lat, output logic [1:0] r, output int aw_n, output int w_n, output bit ok);
        int cyc, last;
        ok = 1'b1; lat = 0; r = '0; aw_n = 0; w_n = 0; cyc = 0; last = 0;
        @(negedge clock);
        awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (lead == 0);
        while (bvalid !== 1'b1 && cyc < 40) begin
            #1;
            if (awvalid && awready) begin aw_n++; last = cyc; end
            if (wvalid && wready) begin w_n++; last = cyc; end
            @(negedge clock);
            cyc++;
            if (cyc >= lead) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (bvalid !== 1'b1) begin ok = 1'b0; return; end
        lat = cyc - last; r = bresp;
        bready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_compared++; if (arready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_arready got %b want 0", arready); end
        n_compared++; if (awready !== 1'b0 || wready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_awready_wready got %b%b want 00", awready, wready); end
        n_compared++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valids got %b%b want 00", rvalid, bvalid); end
        n_compared++; if (rdata !== 32'd0 || rresp !== 2'b00 || bresp !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_payload got %h/%b/%b want 0/00/00", rdata, rresp, bresp); end
        reset = 1'b0;
        #1;
        n_compared++; if (arready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_release_arready got %b want 1", arready); end
    endtask

    task automatic test_write_read();
        int lat, aw_n, w_n; logic [31:0] d; logic [1:0] r; bit ok, st;
        expect_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, lat, r, aw_n, w_n, ok);
        n_compared++; if (!ok || lat != 2) begin n_mismatched++; $display("[TB] FAIL wr_latency got %0d (ok=%0b) want 2", lat, ok); end
        n_compared++; if (r !== wr_resp_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL wr_bresp got %b want 00", r); end
        expect_read(32'h8000_0010);
        do_read(32'h8000_0010, 0, lat, d, r, st, ok);
        n_compared++; if (!ok || lat != 2) begin n_mismatched++; $display("[TB] FAIL rd_latency got %0d (ok=%0b) want 2", lat, ok); end
        n_compared++; if (d !== rd_data_q[0]) begin n_mismatched++; $display("[TB] FAIL rd_data got %h want %h", d, rd_data_q[0]); end
        n_compared++; if (r !== rd_resp_q[0]) begin n_mismatched++; $display("[TB] FAIL rd_resp got %b want %b", r, rd_resp_q[0]); end
        void'(rd_data_q.pop_front()); void'(rd_resp_q.pop_front());
    endtask

    task automatic test_byte_strobe();
        int lat, aw_n, w_n; logic [31:0] d; logic [1:0] r; bit ok, st;
        expect_write(32'h8000_0020, 32'h1122_3344, 4'hF);
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, lat, r, aw_n, w_n, ok);
        void'(wr_resp_q.pop_front());
        expect_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, lat, r, aw_n, w_n, ok);
        n_compared++; if (!ok || r !== wr_resp_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL strb_bresp got %b (ok=%0b) want 00", r, ok); end
        expect_read(32'h8000_0020);
        do_read(32'h8000_0020, 0, lat, d, r, st, ok);
        n_compared++; if (d !== rd_data_q.pop_front() || d !== 32'h11BB_33DD) begin n_mismatched++; $display("[TB] FAIL strb_data got %h want 11bb33dd", d); end
        void'(rd_resp_q.pop_front());
    endtask

    task automatic test_w_before_aw();
        int lat, aw_n, w_n; logic [31:0] d; logic [1:0] r; bit ok, st;
        expect_write(32'h8000_0030, 32'h5A5A_1234, 4'hF);
        do_write(32'h8000_0030, 32'h5A5A_1234, 4'hF, 3, lat, r, aw_n, w_n, ok);
        n_compared++; if (aw_n != 1 || w_n != 1) begin n_mismatched++; $display("[TB] FAIL wfirst_handshakes got aw=%0d w=%0d want 1/1", aw_n, w_n); end
        n_compared++; if (!ok || lat != 2) begin n_mismatched++; $display("[TB] FAIL wfirst_latency got %0d (ok=%0b) want 2", lat, ok); end
        n_compared++; if (r !== wr_resp_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL wfirst_bresp got %b want 00", r); end
        expect_read(32'h8000_0030);
        do_read(32'h8000_0030, 0, lat, d, r, st, ok);
        n_compared++; if (d !== rd_data_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL wfirst_data got %h want 5a5a1234", d); end
        void'(rd_resp_q.pop_front());
    endtask

    task automatic test_out_of_range();
        int lat, aw_n, w_n; logic [31:0] d; logic [1:0] r; bit ok, st;
        expect_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF);
        do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, lat, r, aw_n, w_n, ok);
        void'(wr_resp_q.pop_front());
        expect_read(32'h0200_0048);
        do_read(32'h0200_0048, 0, lat, d, r, st, ok);
        n_compared++; if (d !== rd_data_q.pop_front() || r !== rd_resp_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL oor_read got %h/%b want 0/10", d, r); end
        expect_write(32'h8001_0000, 32'hFFFF_FFFF, 4'hF);
        do_write(32'h8001_0000, 32'hFFFF_FFFF, 4'hF, 0, lat, r, aw_n, w_n, ok);
        n_compared++; if (!ok || r !== wr_resp_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL oor_bresp got %b (ok=%0b) want 10", r, ok); end
        expect_read(32'h8000_0000);
        do_read(32'h8000_0000, 0, lat, d, r, st, ok);
        n_compared++; if (d !== rd_data_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL oor_word0 got %h want cafef00d", d); end
        void'(rd_resp_q.pop_front());
    endtask

    task automatic test_collision();
        int waitc, lat, aw_n, w_n; logic [31:0] d; logic [1:0] r; bit ok, st;
        expect_read(32'h8000_0010);
        expect_write(32'h8000_0040, 32'h0BAD_CAFE, 4'hF);
        @(negedge clock);
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0040; awvalid = 1'b1; wdata = 32'h0BAD_CAFE; wstrb = 4'hF; wvalid = 1'b1;
        #1;
        n_compared++; if (arready !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL coll_ready got ar=%b aw=%b w=%b want 1 0 0", arready, awready, wready); end
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        #1;
        n_compared++; if (awready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL coll_stall got awready=%b want 0", awready); end
        waitc = 0;
        while (rvalid !== 1'b1 && waitc < 20) begin @(negedge clock); waitc++; end
        d = rdata; r = rresp; st = (rvalid === 1'b1);
        repeat (5) begin
            @(negedge clock);
            if (rvalid !== 1'b1 || rdata !== d || rresp !== r || bvalid !== 1'b0) st = 1'b0;
        end
        n_compared++; if (!st) begin n_mismatched++; $display("[TB] FAIL coll_backpressure got rvalid=%b rdata=%h want held 1/%h", rvalid, rdata, d); end
        n_compared++; if (d !== rd_data_q.pop_front() || r !== rd_resp_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL coll_rdata got %h/%b want deadbeef/00", d, r); end
        rready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rready = 1'b0;
        waitc = 0;
        while (bvalid !== 1'b1 && waitc < 20) begin @(negedge clock); waitc++; end
        awvalid = 1'b0; wvalid = 1'b0;
        n_compared++; if (bvalid !== 1'b1 || bresp !== wr_resp_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL coll_write got bvalid=%b bresp=%b want 1/00", bvalid, bresp); end
        bready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bready = 1'b0;
        expect_read(32'h8000_0040);
        do_read(32'h8000_0040, 0, lat, d, r, st, ok);
        n_compared++; if (d !== rd_data_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL coll_readback got %h want 0badcafe", d); end
        void'(rd_resp_q.pop_front());
    endtask

    task automatic test_reset_mid_write();
        int lat, aw_n, w_n; logic [31:0] d; logic [1:0] r; bit ok, st, no_b;
        expect_write(32'h8000_0050, 32'h0102_0304, 4'hF);
        do_write(32'h8000_0050, 32'h0102_0304, 4'hF, 0, lat, r, aw_n, w_n, ok);
        void'(wr_resp_q.pop_front());
        @(negedge clock);
        awaddr = 32'h8000_0050; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n_compared++; if (arready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_mid_arready got %b want 0", arready); end
        reset = 1'b0;
        #1;
        n_compared++; if (arready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_after_arready got %b want 1", arready); end
        no_b = (bvalid === 1'b0);
        repeat (3) begin @(negedge clock); if (bvalid !== 1'b0) no_b = 1'b0; end
        n_compared++; if (!no_b) begin n_mismatched++; $display("[TB] FAIL rst_no_bvalid got bvalid=%b want 0", bvalid); end
        expect_read(32'h8000_0050);
        do_read(32'h8000_0050, 0, lat, d, r, st, ok);
        n_compared++; if (d !== rd_data_q.pop_front()) begin n_mismatched++; $display("[TB] FAIL rst_mem_unchanged got %h want 01020304", d); end
        void'(rd_resp_q.pop_front());
    endtask

    task automatic test_latency0();
        @(negedge clock);
        z_awaddr = 32'h8000_0008; z_wdata = 32'h7766_5544; z_wstrb = 4'hF; z_awvalid = 1'b1; z_wvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        z_awvalid = 1'b0; z_wvalid = 1'b0;
        n_compared++; if (z_bvalid !== 1'b1 || z_bresp !== 2'b00) begin n_mismatched++; $display("[TB] FAIL lat0_bvalid got %b/%b want 1/00", z_bvalid, z_bresp); end
        z_bready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        z_bready = 1'b0;
        z_araddr = 32'h8000_0008; z_arvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        z_arvalid = 1'b0;
        n_compared++; if (z_rvalid !== 1'b1 || z_rdata !== 32'h7766_5544 || z_rresp !== 2'b00) begin n_mismatched++; $display("[TB] FAIL lat0_read got %b/%h/%b want 1/77665544/00", z_rvalid, z_rdata, z_rresp); end
        z_rready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        z_rready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_w_before_aw();
        test_out_of_range();
        test_collision();
        test_reset_mid_write();
        test_latency0();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

endmodule
